// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit feeder: FSM encoding, default FIFO geometry
// and the toggle-handshake synchronizer depth.
package uart_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;
  localparam int ACK_SYNC  = 2;

  // Gray sequence: exactly one bit flips on each IDLE->LOAD->SEND->WAIT->IDLE step
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_SEND = 2'b11,
    ST_WAIT = 2'b10
  } fsm_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 byte FIFO with occupancy counter; clr has priority over push and pop.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enable,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   level
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  // Local guards keep the pointers coherent even if a caller misbehaves
  assign push_ok = push && !clr && (level != (AW+1)'(DEPTH));
  assign pop_ok  = pop  && !clr && (level != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (enable && push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (enable) begin
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        case ({push_ok, pop_ok})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART serializer over a toggle req/ack handshake.
// One byte is in flight at a time; level counts only the bytes still stored.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enable,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          busy,
  output logic          ser_req,
  output logic [7:0]    ser_data,
  input  logic          ser_ack
);

  fsm_t                state_q, state_d;
  logic [ACK_SYNC-1:0] ack_d;
  logic                ack_x;
  logic                push, pop;
  logic [7:0]          fifo_dout;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign push  = wr_en && !full && !clr;
  assign pop   = (state_q == ST_LOAD);
  assign busy  = !((state_q == ST_IDLE) && empty);
  assign ack_x = ack_d[ACK_SYNC-1] ^ ack_d[ACK_SYNC-2];

  uart_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .enable (enable),
    .clr    (clr),
    .push   (push),
    .pop    (pop),
    .din    (wr_data),
    .dout   (fifo_dout),
    .level  (level)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ack_d <= '0;
    else if (enable) ack_d <= {ack_d[ACK_SYNC-2:0], ser_ack};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else if (enable) state_q <= state_d;
  end

  // A clr in IDLE blocks the launch so LOAD never sees a flushed FIFO
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!empty && !clr) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: if (ack_x) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ser_req  <= 1'b0;
      ser_data <= '0;
    end else if (enable) begin
      if (state_q == ST_LOAD) ser_data <= fifo_dout;
      if (state_q == ST_SEND) ser_req  <= ~ser_req;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) overflow <= 1'b0;
    else if (enable) begin
      if (clr) overflow <= 1'b0;
      else if (wr_en && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: latency, ordering, overflow, clr, enable hold, async reset.
module tb_uart_tx_feeder;

  logic       clk, rstn, enable, clr, wr_en;
  logic [7:0] wr_data;
  logic       full, empty, overflow, busy, ser_req, ser_ack;
  logic [4:0] level;
  logic [7:0] ser_data;

  logic       man_ack, auto_ack, resp_en, last_req;
  logic [7:0] got_q [$];
  int         checks, errors, base;

  assign ser_ack = man_ack ^ auto_ack;

  uart_tx_feeder dut (
    .clk(clk), .rstn(rstn), .enable(enable), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow), .busy(busy),
    .ser_req(ser_req), .ser_data(ser_data), .ser_ack(ser_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serializer model: captures the offered byte and echoes each req edge
  initial begin
    last_req = 1'b0;
    auto_ack = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!rstn) last_req = 1'b0;
      else if (resp_en && ser_req !== last_req) begin
        last_req = ser_req;
        got_q.push_back(ser_data);
        auto_ack = ~auto_ack;
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_data = first + 8'(i);
      tick;
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_req(input logic exp, input int max, input string tag);
    int n = 0;
    while (ser_req !== exp && n < max) begin tick; n++; end
    chk(tag, 32'(ser_req), 32'(exp));
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin tick; n++; end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rstn = 1'b0; enable = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_data = '0;
    man_ack = 1'b0; resp_en = 1'b0;
    tick; tick;
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(ser_req), 32'd0);
    chk("rst_data", 32'(ser_data), 32'd0);
    rstn = 1'b1; tick;

    // 1: single byte, latency and ack turnaround
    wr_en = 1'b1; wr_data = 8'hA5; tick; wr_en = 1'b0;
    chk("t1_level", 32'(level), 32'd1);
    tick; tick;
    chk("t1_req_pre", 32'(ser_req), 32'd0);
    chk("t1_data", 32'(ser_data), 32'hA5);
    tick;
    chk("t1_req_edge", 32'(ser_req), 32'd1);
    chk("t1_level0", 32'(level), 32'd0);
    tick; tick; tick;
    man_ack = 1'b1;
    tick;
    chk("t1_busy_hold", 32'(busy), 32'd1);
    tick;
    chk("t1_busy_drop", 32'(busy), 32'd0);

    // 2: back-to-back stream with live responder
    rstn = 1'b0; tick; rstn = 1'b1; tick;
    resp_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      tick;
      chk("t2_not_full", 32'(full), 32'd0);
    end
    wr_en = 1'b0;
    wait_idle(300, "t2_drain");
    chk("t2_count", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      chk("t2_order", 32'(got_q[i]), 32'(i + 1));
    chk("t2_ovf", 32'(overflow), 32'd0);

    // 3: stalled ack, overfill by 4
    resp_en = 1'b0;
    push_burst(8'h20, 20);
    chk("t3_level", 32'(level), 32'd16);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_ovf", 32'(overflow), 32'd1);
    base = got_q.size();
    resp_en = 1'b1;
    wait_idle(400, "t3_drain");
    chk("t3_count", 32'(got_q.size() - base), 32'd17);
    for (int i = 0; i < 17 && base + i < got_q.size(); i++)
      chk("t3_order", 32'(got_q[base + i]), 32'(8'h20 + i));
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);

    // 4: clr with a byte in WAIT and 5 stored
    resp_en = 1'b0;
    push_burst(8'h40, 6);
    chk("t4_level5", 32'(level), 32'd5);
    chk("t4_req", 32'(ser_req), 32'd0);
    chk("t4_data", 32'(ser_data), 32'h40);
    clr = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    tick;
    clr = 1'b0; wr_en = 1'b0;
    chk("t4_clr_level", 32'(level), 32'd0);
    chk("t4_clr_empty", 32'(empty), 32'd1);
    chk("t4_clr_ovf", 32'(overflow), 32'd0);
    chk("t4_busy_wait", 32'(busy), 32'd1);
    man_ack = ~man_ack;
    tick; tick;
    chk("t4_idle", 32'(busy), 32'd0);
    tick; tick; tick; tick;
    chk("t4_no_req", 32'(ser_req), 32'd0);

    // 5: enable low mid-WAIT while ack toggles
    push_burst(8'h55, 1);
    wait_req(1'b1, 10, "t5_req");
    tick; tick;
    enable = 1'b0; wr_en = 1'b1; wr_data = 8'h66;
    for (int i = 0; i < 10; i++) begin
      if (i == 1 || i == 4 || i == 7) man_ack = ~man_ack;
      tick;
    end
    chk("t5_hold_busy", 32'(busy), 32'd1);
    chk("t5_hold_level", 32'(level), 32'd0);
    chk("t5_hold_req", 32'(ser_req), 32'd1);
    chk("t5_hold_data", 32'(ser_data), 32'h55);
    wr_en = 1'b0; enable = 1'b1;
    tick;
    chk("t5_ack_sync", 32'(busy), 32'd1);
    tick;
    chk("t5_ack_done", 32'(busy), 32'd0);

    // 6: async reset during WAIT
    push_burst(8'h70, 3);
    wait_req(1'b0, 10, "t6_req0");
    man_ack = ~man_ack;
    wait_req(1'b1, 20, "t6_req1");
    tick;
    chk("t6_level1", 32'(level), 32'd1);
    chk("t6_data", 32'(ser_data), 32'h71);
    rstn = 1'b0; #1;
    chk("t6_rst_req", 32'(ser_req), 32'd0);
    chk("t6_rst_data", 32'(ser_data), 32'd0);
    chk("t6_rst_level", 32'(level), 32'd0);
    chk("t6_rst_empty", 32'(empty), 32'd1);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    tick; rstn = 1'b1; tick;
    push_burst(8'h99, 1);
    tick; tick;
    chk("t6_restart_pre", 32'(ser_req), 32'd0);
    tick;
    chk("t6_restart_req", 32'(ser_req), 32'd1);
    chk("t6_restart_data", 32'(ser_data), 32'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
